evm: RTL and testbench
======================

// Module: evm
// PURPOSE
// - Four-candidate electronic voting machine core: counts one vote per VOTE strobe
//   for the candidate selected on S, exposes all four tallies and the current leader.
// - Sits between the ballot-unit input logic (buttons/debounce) and the result display.
// - Single clock domain; all outputs registered.
// PARAMETERS
// - CNT_W   32   width of each tally counter (RESULT0..3 width)
// PORTS
// - CLK      in   1      system clock, all state updates on rising edge
// - RESET    in   1      asynchronous, active-high; clears all state
// - VOTE     in   1      vote strobe; one vote per 0->1 transition
// - S        in   2      candidate select (0..3), sampled with VOTE
// - RESULT0  out  CNT_W  tally of candidate 0
// - RESULT1  out  CNT_W  tally of candidate 1
// - RESULT2  out  CNT_W  tally of candidate 2
// - RESULT3  out  CNT_W  tally of candidate 3
// - WINNER   out  2      index of candidate with highest tally
// BEHAVIOUR
// - Reset (async assert, sync release): RESULT0..3 = 0, WINNER = 0, vote_q = 1.
// - vote_q = VOTE registered each cycle; rise = VOTE & ~vote_q.
//   vote_q resets to 1: VOTE held high across reset release casts no vote.
// - Edge k with rise=1: RESULT[S] += 1; visible after edge k. Other tallies hold.
// - VOTE held high any number of cycles = exactly one vote; re-arm needs VOTE low >=1 cycle.
// - S is sampled only on the rise cycle; S changes at other times are ignored.
// - Saturation: tally at 2^CNT_W-1 stays there; no wrap; other tallies unaffected.
// - WINNER registered from the tallies: at edge k+1 reflects tallies after edge k
//   (one cycle latency behind RESULTx).
// - WINNER = argmax(RESULT0..3); ties resolve to the lowest index. All zero -> 0.
// - RESET mid-operation: immediate clear regardless of VOTE/S; a rise pending in the
//   reset cycle is lost.
// - Unsigned compares only; no arithmetic other than +1 per tally.
// CONFIGURATION
// - Macro EVM_SYNC_EN.
//   Defined: VOTE and S each pass a 2-flop synchronizer (reset to VOTE=1, S=0) before edge
//   detect; tally update latency +2 cycles (rise at synced output), WINNER +2 likewise.
//   Undefined: VOTE and S used directly; caller guarantees they are synchronous to CLK.
// STRUCTURE
// - Package evm_pkg: NUM_CAND = 4, localparam CNT_W_DEF = 32, typedef cand_t = logic [1:0].
// - Sub-module evm_winner: combinational 4-input argmax (pairwise compare tree, lower index
//   wins ties), parameterised by CNT_W; evm registers its output into WINNER.
// - evm top: optional synchronizer, edge detector, four saturating counters, WINNER register.
// TESTING
// - Reset then VOTE pulses with S = 2,0,1,3,1,2,1 -> RESULT0..3 = 1,3,2,1; WINNER = 1
//   one cycle after last tally update.
// - Votes S=2 then S=3 only -> RESULT2=1, RESULT3=1, tie -> WINNER = 2; no votes -> WINNER=0.
// - VOTE held high 5 cycles with S=0 toggling S mid-pulse -> RESULT0 = 1 only; VOTE high
//   through RESET release -> all tallies stay 0.
// - CNT_W=4, 17 pulses on S=3 -> RESULT3 = 15 (saturated), others 0, WINNER = 3.
// - RESET asserted mid-sequence (between clock edges) -> all RESULTx and WINNER = 0
//   immediately; next pulse on S=1 -> RESULT1 = 1.
// - EVM_SYNC_EN defined: pulse on S=2 -> RESULT2 increments 2 cycles later than undefined
//   build; WINNER follows 1 cycle after.

Source files
------------

// File: rtl/evm_pkg.sv
// evm_pkg: shared constants and types for the four-candidate voting core.
package evm_pkg;
    localparam int NUM_CAND  = 4;
    localparam int CNT_W_DEF = 32;
    typedef logic [1:0] cand_t;
endpackage

// File: rtl/evm_winner.sv
// evm_winner: combinational argmax over four tallies, lower index wins ties.
module evm_winner
    import evm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] r0_i,
    input  logic [CNT_W-1:0] r1_i,
    input  logic [CNT_W-1:0] r2_i,
    input  logic [CNT_W-1:0] r3_i,
    output cand_t            win_o
);
    cand_t            idx_a, idx_b;
    logic [CNT_W-1:0] val_a, val_b;
    // Strict greater-than keeps the lower index on equality at every level.
    always_comb begin
        idx_a = (r1_i > r0_i) ? 2'd1 : 2'd0;
        val_a = (r1_i > r0_i) ? r1_i : r0_i;
        idx_b = (r3_i > r2_i) ? 2'd3 : 2'd2;
        val_b = (r3_i > r2_i) ? r3_i : r2_i;
        win_o = (val_b > val_a) ? idx_b : idx_a;
    end
endmodule

// File: rtl/evm.sv
// evm: four-candidate voting core with saturating tallies and registered leader.
// Define EVM_SYNC_EN to pass VOTE and S through 2-flop synchronizers first.
module evm
    import evm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VOTE,
    input  logic [1:0]       S,
    output logic [CNT_W-1:0] RESULT0,
    output logic [CNT_W-1:0] RESULT1,
    output logic [CNT_W-1:0] RESULT2,
    output logic [CNT_W-1:0] RESULT3,
    output logic [1:0]       WINNER
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             vote_in;
    cand_t            s_in;
    logic             vote_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q [NUM_CAND];
    logic [CNT_W-1:0] cnt_d [NUM_CAND];
    cand_t            win_d, win_q;

`ifdef EVM_SYNC_EN
    logic [1:0] vote_sync_q;
    cand_t      s_sync1_q, s_sync2_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vote_sync_q <= 2'b11;
            s_sync1_q   <= '0;
            s_sync2_q   <= '0;
        end else begin
            vote_sync_q <= {vote_sync_q[0], VOTE};
            s_sync1_q   <= S;
            s_sync2_q   <= s_sync1_q;
        end
    end
    assign vote_in = vote_sync_q[1];
    assign s_in    = s_sync2_q;
`else
    assign vote_in = VOTE;
    assign s_in    = S;
`endif

    // vote_q resets high so a strobe held across reset release is not a vote.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) vote_q <= 1'b1;
        else       vote_q <= vote_in;
    end
    assign rise = vote_in & ~vote_q;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_cnt
        assign cnt_d[g] = (rise && s_in == cand_t'(g) && cnt_q[g] != CNT_MAX) ?
                          cnt_q[g] + 1'b1 : cnt_q[g];
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) cnt_q[g] <= '0;
            else       cnt_q[g] <= cnt_d[g];
        end
    end

    evm_winner #(.CNT_W(CNT_W)) u_winner (
        .r0_i  (cnt_q[0]),
        .r1_i  (cnt_q[1]),
        .r2_i  (cnt_q[2]),
        .r3_i  (cnt_q[3]),
        .win_o (win_d)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) win_q <= '0;
        else       win_q <= win_d;
    end

    assign RESULT0 = cnt_q[0];
    assign RESULT1 = cnt_q[1];
    assign RESULT2 = cnt_q[2];
    assign RESULT3 = cnt_q[3];
    assign WINNER  = win_q;
endmodule

// File: tb/tb_evm.sv
// tb_evm: directed self-checking bench for evm (default and 4-bit tally builds).
module tb_evm;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VOTE = 1'b0;
    logic [1:0]  S = 2'd0;
    logic [31:0] r0, r1, r2, r3;
    logic [1:0]  w;
    logic [3:0]  sr0, sr1, sr2, sr3;
    logic [1:0]  sw;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    evm #(.CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .VOTE(VOTE), .S(S),
        .RESULT0(r0), .RESULT1(r1), .RESULT2(r2), .RESULT3(r3), .WINNER(w)
    );

    evm #(.CNT_W(4)) dut_sm (
        .CLK(CLK), .RESET(RESET), .VOTE(VOTE), .S(S),
        .RESULT0(sr0), .RESULT1(sr1), .RESULT2(sr2), .RESULT3(sr3), .WINNER(sw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [1:0] sel);
        S = sel;
        VOTE = 1'b1;
        tick();
        VOTE = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        VOTE = 1'b0;
        S = 2'd0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        logic [1:0] seq [7] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd2, 2'd1};
        do_reset();
        check("rst_r0", r0, 0);
        check("rst_r1", r1, 0);
        check("rst_r2", r2, 0);
        check("rst_r3", r3, 0);
        check("rst_win", w, 0);

        foreach (seq[i]) pulse(seq[i]);
        check("seq_r0", r0, 1);
        check("seq_r1", r1, 3);
        check("seq_r2", r2, 2);
        check("seq_r3", r3, 1);
        check("seq_win", w, 1);

        do_reset();
        S = 2'd2;
        VOTE = 1'b1;
        tick();
        check("lat_r2", r2, 1);
        check("lat_win_old", w, 0);
        VOTE = 1'b0;
        tick();
        check("lat_win_new", w, 2);
        pulse(2'd3);
        check("tie_r3", r3, 1);
        check("tie_win", w, 2);

        do_reset();
        S = 2'd0;
        VOTE = 1'b1;
        tick();
        tick();
        S = 2'd1;
        tick();
        S = 2'd2;
        tick();
        tick();
        VOTE = 1'b0;
        tick();
        check("hold_r0", r0, 1);
        check("hold_r1", r1, 0);
        check("hold_r2", r2, 0);

        RESET = 1'b1;
        VOTE = 1'b1;
        S = 2'd1;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        tick();
        tick();
        check("thru_r0", r0, 0);
        check("thru_r1", r1, 0);
        check("thru_r2", r2, 0);
        check("thru_r3", r3, 0);
        VOTE = 1'b0;
        tick();
        pulse(2'd1);
        check("rearm_r1", r1, 1);

        do_reset();
        for (int i = 0; i < 17; i++) pulse(2'd3);
        check("sat_r3", sr3, 15);
        check("sat_r0", sr0, 0);
        check("sat_r1", sr1, 0);
        check("sat_r2", sr2, 0);
        check("sat_win", sw, 3);
        check("wide_r3", r3, 17);

        do_reset();
        pulse(2'd0);
        pulse(2'd2);
        pulse(2'd2);
        check("pre_r2", r2, 2);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_r0", r0, 0);
        check("mid_r2", r2, 0);
        check("mid_win", w, 0);
        tick();
        RESET = 1'b0;
        tick();
        pulse(2'd1);
        check("post_r1", r1, 1);
        check("post_r0", r0, 0);
        check("post_win", w, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
